// File: rtl/ser_bus_tx.sv
// ser_bus_tx: bus-mapped asynchronous serial transmitter for the serial-select
// window (~sser_n & ~ba13 & ba12). A one-deep holding register feeds a frame
// shifter: start bit, 8 data bits LSB first, optional even parity, stop bit.
// Optional feature macro: SER_TX_PARITY_EN (adds the parity bit, 11-bit frames).
//
// Register map (ba7_4):
//   0x0 write TXD    : load holding register (dropped with sticky overrun if full)
//   0x1 write CTRL   : bit0 irq_en, bit1 flush (self-clearing)
//   0x2 read  STATUS : {4'b0, irq_en, overrun, busy, hold_full}; clears overrun
//
// Bus handshake: a transfer happens on every rising edge where bus_stb is high
// and the window is selected; there is no back-pressure. Read data appears on
// bd_o with bd_oe high for exactly the one cycle after the access edge.
module ser_bus_tx #(
    parameter int CLK_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sser_n,
    input  logic       ba13,
    input  logic       ba12,
    input  logic [3:0] ba7_4,
    input  logic       br_w,
    input  logic       bus_stb,
    input  logic [7:0] bd_i,
    output logic [7:0] bd_o,
    output logic       bd_oe,
    output logic       sdwr,
    output logic       busy,
    output logic       irq
);

    localparam int TW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [TW-1:0] T_RELOAD = TW'(CLK_DIV - 1);

`ifdef SER_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd4
    } state_t;
`endif

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [2:0]    bit_idx, bit_nxt;
    logic [7:0]    shifter, shifter_nxt;
    logic          sdwr_nxt;
    logic          xfer;
    logic [7:0]    hold_reg;
    logic          hold_full, hold_full_nxt;
    logic          overrun;
    logic          irq_en, irq_en_nxt;
    logic          acc, wr_txd, wr_ctrl, rd_stat, flush, ovr_set, hold_load, tick;
`ifdef SER_TX_PARITY_EN
    logic          par_bit;
`endif

    // Bus access decode
    assign acc     = bus_stb & ~sser_n & ~ba13 & ba12;
    assign wr_txd  = acc & ~br_w & (ba7_4 == 4'h0);
    assign wr_ctrl = acc & ~br_w & (ba7_4 == 4'h1);
    assign rd_stat = acc &  br_w & (ba7_4 == 4'h2);
    assign flush   = wr_ctrl & bd_i[1];
    assign tick    = (timer == '0);
    assign busy    = (state != S_IDLE);

    // A byte arriving while the holding register stays occupied is dropped.
    // When the shifter takes the old byte this same edge, the new one fits.
    assign ovr_set       = wr_txd & ~flush & hold_full & ~xfer;
    assign hold_load     = wr_txd & ~flush & ~(hold_full & ~xfer);
    assign hold_full_nxt = ~flush & (wr_txd | (hold_full & ~xfer));
    assign irq_en_nxt    = wr_ctrl ? bd_i[0] : irq_en;

    // FSM state, bit timer, shifter and registered line output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            timer   <= '0;
            bit_idx <= 3'd0;
            shifter <= 8'h00;
            sdwr    <= 1'b1;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            bit_idx <= bit_nxt;
            shifter <= shifter_nxt;
            sdwr    <= sdwr_nxt;
        end
    end

    // Next-state logic; sdwr_nxt is the line level for the state being entered
    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        bit_nxt     = bit_idx;
        shifter_nxt = shifter;
        sdwr_nxt    = sdwr;
        xfer        = 1'b0;
        if (flush) begin
            state_nxt = S_IDLE;
            timer_nxt = '0;
            bit_nxt   = 3'd0;
            sdwr_nxt  = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    sdwr_nxt = 1'b1;
                    if (hold_full) begin
                        xfer = 1'b1;
                    end
                end
                S_START: begin
                    if (tick) begin
                        state_nxt   = S_DATA;
                        timer_nxt   = T_RELOAD;
                        bit_nxt     = 3'd0;
                        sdwr_nxt    = shifter[0];
                        shifter_nxt = shifter >> 1;
                    end else begin
                        timer_nxt = timer - TW'(1);
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        timer_nxt = T_RELOAD;
                        if (bit_idx == 3'd7) begin
`ifdef SER_TX_PARITY_EN
                            state_nxt = S_PAR;
                            sdwr_nxt  = par_bit;
`else
                            state_nxt = S_STOP;
                            sdwr_nxt  = 1'b1;
`endif
                        end else begin
                            bit_nxt     = bit_idx + 3'd1;
                            sdwr_nxt    = shifter[0];
                            shifter_nxt = shifter >> 1;
                        end
                    end else begin
                        timer_nxt = timer - TW'(1);
                    end
                end
`ifdef SER_TX_PARITY_EN
                S_PAR: begin
                    if (tick) begin
                        state_nxt = S_STOP;
                        timer_nxt = T_RELOAD;
                        sdwr_nxt  = 1'b1;
                    end else begin
                        timer_nxt = timer - TW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (tick) begin
                        if (hold_full) begin
                            xfer = 1'b1;
                        end else begin
                            state_nxt = S_IDLE;
                            timer_nxt = '0;
                            sdwr_nxt  = 1'b1;
                        end
                    end else begin
                        timer_nxt = timer - TW'(1);
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    timer_nxt = '0;
                    sdwr_nxt  = 1'b1;
                end
            endcase
            if (xfer) begin
                state_nxt   = S_START;
                timer_nxt   = T_RELOAD;
                bit_nxt     = 3'd0;
                shifter_nxt = hold_reg;
                sdwr_nxt    = 1'b0;
            end
        end
    end

    // Holding register, sticky overrun, control and interrupt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_reg  <= 8'h00;
            hold_full <= 1'b0;
            overrun   <= 1'b0;
            irq_en    <= 1'b0;
            irq       <= 1'b0;
        end else begin
            if (hold_load) begin
                hold_reg <= bd_i;
            end
            hold_full <= hold_full_nxt;
            overrun   <= ovr_set | (overrun & ~rd_stat);
            irq_en    <= irq_en_nxt;
            irq       <= irq_en_nxt & ~hold_full_nxt;
        end
    end

`ifdef SER_TX_PARITY_EN
    // Even parity of the byte captured into the shifter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_bit <= 1'b0;
        end else if (xfer) begin
            par_bit <= ^hold_reg;
        end
    end
`endif

    // Read data: one-cycle pulse, zero outside a read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bd_o  <= 8'h00;
            bd_oe <= 1'b0;
        end else begin
            bd_oe <= acc & br_w;
            bd_o  <= rd_stat ? {4'b0000, irq_en, overrun, busy, hold_full} : 8'h00;
        end
    end

endmodule

// File: tb/tb_ser_bus_tx.sv
// tb_ser_bus_tx: randomized and directed bench for ser_bus_tx (CLK_DIV=4).
// The reference model keeps accepted bytes with the edge they were written and
// the edge their frame starts; line level, busy, holding state and irq for any
// cycle are computed from that schedule with plain arithmetic.
module tb_ser_bus_tx;
  localparam int D = 4;
`ifdef SER_TX_PARITY_EN
  localparam int FL = 11 * D;
`else
  localparam int FL = 10 * D;
`endif

  logic clk, rst, sser_n, ba13, ba12, br_w, bus_stb;
  logic [3:0] ba7_4;
  logic [7:0] bd_i, bd_o;
  logic bd_oe, sdwr, busy, irq;

  ser_bus_tx #(.CLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .sser_n(sser_n), .ba13(ba13), .ba12(ba12),
    .ba7_4(ba7_4), .br_w(br_w), .bus_stb(bus_stb), .bd_i(bd_i),
    .bd_o(bd_o), .bd_oe(bd_oe), .sdwr(sdwr), .busy(busy), .irq(irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  bit check_en = 0;

  // scoreboard: accepted bytes with write edge and frame start edge
  logic [7:0] exp_q[$];
  int start_q[$];
  int wr_q[$];
  bit ovr_m = 0;
  bit ien_old = 0, ien_new = 0;
  int ien_edge = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int find_frame(int e);
    for (int i = 0; i < start_q.size(); i++)
      if (wr_q[i] <= e && e >= start_q[i] && e < start_q[i] + FL) return i;
    return -1;
  endfunction

  function automatic logic exp_line(int e);
    int i;
    int k;
    logic [7:0] b;
    i = find_frame(e);
    if (i < 0) return 1'b1;
    b = exp_q[i];
    k = (e - start_q[i]) / D;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef SER_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  function automatic logic exp_busy(int e);
    return find_frame(e) >= 0;
  endfunction

  function automatic logic exp_hold(int e);
    for (int i = 0; i < start_q.size(); i++)
      if (wr_q[i] <= e && e < start_q[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic ien(int e);
    return (e >= ien_edge) ? ien_new : ien_old;
  endfunction

  task automatic model_write(input int w, input logic [7:0] b);
    int s;
    for (int i = 0; i < start_q.size(); i++)
      if (start_q[i] > w) begin
        ovr_m = 1;
        return;
      end
    s = w + 1;
    if (start_q.size() > 0 && start_q[start_q.size()-1] + FL > s) s = start_q[start_q.size()-1] + FL;
    exp_q.push_back(b);
    start_q.push_back(s);
    wr_q.push_back(w);
  endtask

  task automatic clear_model();
    exp_q.delete();
    start_q.delete();
    wr_q.delete();
  endtask

  // per-cycle line / busy / irq comparison against the schedule
  always @(negedge clk) begin
    if (check_en) begin
      check("sdwr", 8'(sdwr), 8'(exp_line(cyc)));
      check("busy", 8'(busy), 8'(exp_busy(cyc)));
      check("irq", 8'(irq), 8'(ien(cyc) & ~exp_hold(cyc)));
    end
  end

  // driver tasks (entered just after a falling edge)
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_acc(input logic sn, input logic a13, input logic a12,
                         input logic [3:0] off, input logic rw, input logic [7:0] d);
    sser_n = sn; ba13 = a13; ba12 = a12; ba7_4 = off; br_w = rw; bd_i = d; bus_stb = 1'b1;
    @(negedge clk);
    bus_stb = 1'b0; sser_n = 1'b1; br_w = 1'b1; bd_i = 8'h00;
  endtask

  task automatic write_txd(input logic [7:0] b);
    model_write(cyc + 1, b);
    bus_acc(1'b0, 1'b0, 1'b1, 4'h0, 1'b0, b);
  endtask

  task automatic write_ctrl(input logic [7:0] v);
    ien_old = ien(cyc);
    ien_new = v[0];
    ien_edge = cyc + 1;
    if (v[1]) check_en = 0;
    bus_acc(1'b0, 1'b0, 1'b1, 4'h1, 1'b0, v);
    if (v[1]) begin
      clear_model();
      check("flush_sdwr", 8'(sdwr), 8'h01);
      check("flush_busy", 8'(busy), 8'h00);
      check_en = 1;
    end
  endtask

  task automatic read_status(output logic [7:0] got);
    logic [7:0] exp;
    exp = {4'b0000, ien(cyc), ovr_m, exp_busy(cyc), exp_hold(cyc)};
    ovr_m = 0;
    bus_acc(1'b0, 1'b0, 1'b1, 4'h2, 1'b1, 8'h00);
    got = bd_o;
    check("status", bd_o, exp);
    check("status_oe", 8'(bd_oe), 8'h01);
    idle(1);
    check("rd_oe_drop", 8'(bd_oe), 8'h00);
    check("rd_bd_zero", bd_o, 8'h00);
  endtask

  // decode-miss access: 0 = sser_n high, 1 = ba13 high, 2 = offset 0x7
  task automatic stray_acc(input int kind, input logic rw, input logic [7:0] d);
    case (kind)
      0: bus_acc(1'b1, 1'b0, 1'b1, 4'h0, rw, d);
      1: bus_acc(1'b0, 1'b1, 1'b1, 4'h1, rw, d);
      default: bus_acc(1'b0, 1'b0, 1'b1, 4'h7, rw, d);
    endcase
    if (rw) begin
      check("stray_rd", bd_o, 8'h00);
      if (kind == 2) check("stray_oe", 8'(bd_oe), 8'h01);
    end
  endtask

  initial begin
    logic [7:0] st;
    int cnt;
    int tgt;
    int n;
    rst = 1'b1; bus_stb = 1'b0; sser_n = 1'b1; ba13 = 1'b0; ba12 = 1'b0;
    ba7_4 = 4'h0; br_w = 1'b1; bd_i = 8'h00;
    idle(3);
    check("rst_sdwr", 8'(sdwr), 8'h01);
    check("rst_busy", 8'(busy), 8'h00);
    check("rst_irq", 8'(irq), 8'h00);
    check("rst_bd_o", bd_o, 8'h00);
    check("rst_bd_oe", 8'(bd_oe), 8'h00);
    rst = 1'b0;
    check_en = 1;
    idle(2);

    // single frame 0x55, busy length
    write_txd(8'h55);
    cnt = 0;
    repeat (FL + 10) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    check("busy_len", 8'(cnt), 8'(FL));

    // back-to-back frames, write lands on the transfer edge
    write_txd(8'hA3);
    write_txd(8'h3C);
    read_status(st);
    check("b2b_no_ovr", 8'(st[2]), 8'h00);
    idle(2 * FL + 5);

    // three writes within one frame
    write_txd(8'h11);
    write_txd(8'h22);
    write_txd(8'h33);
    read_status(st);
    check("ovr_status", st, 8'h07);
    read_status(st);
    check("ovr_cleared", st, 8'h03);
    idle(2 * FL + 5);

    // irq handshake and parity bytes
    write_ctrl(8'h01);
    idle(1);
    check("irq_on", 8'(irq), 8'h01);
    write_txd(8'h00);
    check("irq_drop", 8'(irq), 8'h00);
    idle(1);
    check("irq_rise", 8'(irq), 8'h01);
    idle(FL + 3);
    write_txd(8'h01);
    idle(FL + 3);
    write_ctrl(8'h00);

    // reset during data bit 3 of 0xF0
    write_txd(8'hF0);
    tgt = start_q[start_q.size()-1] + 4 * D + 1;
    n = 0;
    while (cyc < tgt && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_wait_timeout", 8'(n >= 200), 8'h00);
    check("bit3_low", 8'(sdwr), 8'h00);
    check_en = 0;
    #1 rst = 1'b1;
    #1;
    check("async_rst_sdwr", 8'(sdwr), 8'h01);
    check("async_rst_busy", 8'(busy), 8'h00);
    idle(3);
    rst = 1'b0;
    clear_model();
    ovr_m = 0; ien_old = 0; ien_new = 0; ien_edge = 0;
    check_en = 1;
    read_status(st);
    check("post_rst_status", st, 8'h00);
    idle(FL + 5);

    // decode misses change nothing
    stray_acc(0, 1'b0, 8'h5A);
    stray_acc(1, 1'b0, 8'h01);
    stray_acc(2, 1'b0, 8'hC3);
    stray_acc(0, 1'b1, 8'h00);
    stray_acc(1, 1'b1, 8'h00);
    stray_acc(2, 1'b1, 8'h00);
    read_status(st);
    check("stray_status", st, 8'h00);
    idle(5);

    // flush mid-frame with a byte waiting
    write_txd(8'h96);
    idle(3 * D);
    write_txd(8'h69);
    write_ctrl(8'h02);
    read_status(st);
    check("flush_status", st, 8'h00);
    idle(FL + 5);

    // randomized traffic
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: write_txd(8'($urandom_range(0, 255)));
        5, 6: read_status(st);
        7: write_ctrl(8'($urandom_range(0, 1)));
        8: stray_acc($urandom_range(0, 2), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        default: idle($urandom_range(0, FL));
      endcase
      idle($urandom_range(0, 6 * D));
    end
    idle(3 * FL);
    check_en = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
